// File: rtl/sc_scbc_pkg.sv
// sc_scbc_pkg: shared arbiter state type and ULPI register addresses
package sc_scbc_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, COMP} ula_state_t;
    localparam logic [7:0] VENDOR_ID_LO = 8'h00;
    localparam logic [7:0] FUNC_CTRL    = 8'h04;
    localparam logic [7:0] OTG_CTRL     = 8'h0A;
    localparam logic [7:0] DEBUG        = 8'h15;
    localparam logic [7:0] SCRATCH      = 8'h16;
endpackage

// File: rtl/sc_scbc_rrpick.sv
// sc_scbc_rrpick: combinational round-robin picker, first set request at or after ptr
module sc_scbc_rrpick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 vld,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);
    assign vld = |req;
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/sc_scbc_ula.sv
// sc_scbc_ula: round-robin arbiter serialising ULPI register accesses with timeout
module sc_scbc_ula
    import sc_scbc_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ULPICLK,
    input  logic                    ULPIRST,
    input  logic [NREQ-1:0]         RQ_REQ,
    input  logic [NREQ-1:0]         RQ_WR0RD1,
    input  logic [NREQ*8-1:0]       RQ_ADDR,
    input  logic [NREQ*8-1:0]       RQ_WRDATA,
    output logic [NREQ-1:0]         RQ_ACK,
    output logic                    RQ_ERR,
    output logic [7:0]              RQ_RDDATA,
    output logic                    ULLA_REQ,
    input  logic                    ULLA_ACK,
    output logic                    ULLA_WR0RD1,
    output logic [7:0]              ULLA_ADDR,
    output logic [7:0]              ULLA_WRDATA,
    input  logic [7:0]              URC_DATA,
    output logic                    BUSY,
    output logic [$clog2(NREQ)-1:0] GRANT_ID
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    ula_state_t state, state_nx;
    logic [GW-1:0] ptr, pick_idx;
    logic pick_vld, tmo;
    logic [CW-1:0] cnt;
    sc_scbc_rrpick #(.N(NREQ)) u_pick (
        .req(RQ_REQ),
        .ptr(ptr),
        .vld(pick_vld),
        .idx(pick_idx)
    );
    assign tmo    = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign BUSY   = state != IDLE;
    assign RQ_ACK = state == COMP ? NREQ'(1) << GRANT_ID : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pick_vld ? ISSUE : IDLE;
            ISSUE:   state_nx = (ULLA_ACK || tmo) ? COMP : ISSUE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge ULPICLK) begin
        if (ULPIRST) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ULLA_REQ    <= 1'b0;
            ULLA_WR0RD1 <= 1'b0;
            ULLA_ADDR   <= '0;
            ULLA_WRDATA <= '0;
            RQ_ERR      <= 1'b0;
            RQ_RDDATA   <= '0;
            GRANT_ID    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_vld) begin
                GRANT_ID    <= pick_idx;
                ULLA_REQ    <= 1'b1;
                ULLA_WR0RD1 <= RQ_WR0RD1[pick_idx];
                ULLA_ADDR   <= RQ_ADDR[8*pick_idx +: 8];
                ULLA_WRDATA <= RQ_WRDATA[8*pick_idx +: 8];
                cnt         <= '0;
            end
            if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
                // an ACK arriving on the timeout cycle still counts as success
                if (ULLA_ACK || tmo) begin
                    ULLA_REQ <= 1'b0;
                    RQ_ERR   <= !ULLA_ACK;
                end
                if (ULLA_ACK && ULLA_WR0RD1) RQ_RDDATA <= URC_DATA;
            end
            if (state == COMP) ptr <= GRANT_ID == GW'(NREQ - 1) ? '0 : GRANT_ID + 1'b1;
        end
    end
endmodule

// File: tb/tb_sc_scbc_ula.sv
// tb_sc_scbc_ula: directed and randomized checks of the ULPI access arbiter against a transaction model
module tb_sc_scbc_ula;
    import sc_scbc_pkg::*;
    localparam int N = 3;
    localparam int T = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] rq_req = '0, rq_wr0rd1 = '0;
    logic [N*8-1:0] rq_addr = '0, rq_wrdata = '0;
    logic [N-1:0] rq_ack;
    logic rq_err, ulla_req, ulla_wr0rd1, busy;
    logic ulla_ack = 1'b0;
    logic [7:0] rq_rddata, ulla_addr, ulla_wrdata;
    logic [7:0] urc_data = '0;
    logic [1:0] grant_id;
    int total = 0, bad = 0, mptr = 0, g = 0;
    logic [7:0] mrd = '0;

    sc_scbc_ula #(.NREQ(N), .TIMEOUT_CYCLES(T)) dut (
        .ULPICLK(clk), .ULPIRST(rst),
        .RQ_REQ(rq_req), .RQ_WR0RD1(rq_wr0rd1), .RQ_ADDR(rq_addr), .RQ_WRDATA(rq_wrdata),
        .RQ_ACK(rq_ack), .RQ_ERR(rq_err), .RQ_RDDATA(rq_rddata),
        .ULLA_REQ(ulla_req), .ULLA_ACK(ulla_ack), .ULLA_WR0RD1(ulla_wr0rd1),
        .ULLA_ADDR(ulla_addr), .ULLA_WRDATA(ulla_wrdata), .URC_DATA(urc_data),
        .BUSY(busy), .GRANT_ID(grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        rq_wr0rd1[i]        = wr;
        rq_addr[8*i +: 8]   = a;
        rq_wrdata[8*i +: 8] = d;
        rq_req[i]           = 1'b1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // runs one access from an IDLE cycle through to the COMP cycle; ack_at >= T means no ULLA_ACK
    task automatic access(input int ack_at, input logic [7:0] urc, output int gr);
        int hi;
        logic err;
        hi = 0;
        gr = pick(rq_req, mptr);
        chk("idle_ulla_req", ulla_req, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("ulla_req_rise", ulla_req, 1);
        chk("grant_id", grant_id, gr);
        chk("ulla_wr0rd1", ulla_wr0rd1, rq_wr0rd1[gr]);
        chk("ulla_addr", ulla_addr, rq_addr[8*gr +: 8]);
        chk("ulla_wrdata", ulla_wrdata, rq_wrdata[8*gr +: 8]);
        chk("issue_busy", busy, 1);
        for (int j = 0; j < T; j++) begin
            hi += (ulla_req === 1'b1) ? 1 : 0;
            ulla_ack = (j == ack_at);
            urc_data = (j == ack_at) ? urc : 8'($urandom);
            tick();
            ulla_ack = 1'b0;
            if (j == ack_at) break;
        end
        err = ack_at >= T;
        if (!err && rq_wr0rd1[gr]) mrd = urc;
        chk("ulla_req_cycles", hi, err ? T : ack_at + 1);
        chk("comp_rq_ack", rq_ack, 1 << gr);
        chk("comp_rq_err", rq_err, err);
        chk("comp_rddata", rq_rddata, mrd);
        chk("comp_ulla_req", ulla_req, 0);
        chk("comp_busy", busy, 1);
        mptr = (gr + 1) % N;
    endtask

    task automatic after_comp(input int gr);
        tick();
        chk("ack_one_cycle", rq_ack, 0);
        chk("grant_id_hold", grant_id, gr);
        chk("back_idle_busy", busy, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rq_ack", rq_ack, 0);
        chk("rst_rq_err", rq_err, 0);
        chk("rst_rddata", rq_rddata, 0);
        chk("rst_ulla_req", ulla_req, 0);
        chk("rst_ulla_wr0rd1", ulla_wr0rd1, 0);
        chk("rst_ulla_addr", ulla_addr, 0);
        chk("rst_ulla_wrdata", ulla_wrdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);

        ulla_ack = 1'b1;
        urc_data = 8'h5A;
        tick();
        ulla_ack = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_rq_ack", rq_ack, 0);
        chk("stray_rddata", rq_rddata, 0);
        tick();
        chk("stray_ulla_req", ulla_req, 0);

        set_req(1, 1'b0, SCRATCH, 8'hA5);
        access(5, 8'h77, g);
        chk("write_grant", g, 1);
        rq_req = '0;
        after_comp(g);

        set_req(0, 1'b1, VENDOR_ID_LO, 8'h00);
        access(1, 8'h24, g);
        rq_req = '0;
        after_comp(g);
        chk("read_held", rq_rddata, 8'h24);
        set_req(2, 1'b0, FUNC_CTRL, 8'h41);
        access(0, 8'h99, g);
        rq_req = '0;
        after_comp(g);
        chk("read_kept_after_write", rq_rddata, 8'h24);

        set_req(0, 1'b1, DEBUG, 8'h11);
        set_req(1, 1'b0, OTG_CTRL, 8'h22);
        set_req(2, 1'b1, SCRATCH, 8'h33);
        for (int k = 0; k < 6; k++) begin
            access(2, 8'($urandom), g);
            chk("rr_order", g, k % N);
            after_comp(g);
        end
        rq_req = '0;

        set_req(1, 1'b1, SCRATCH, 8'h00);
        access(T + 5, 8'hEE, g);
        rq_req = '0;
        after_comp(g);
        set_req(2, 1'b1, DEBUG, 8'h00);
        access(T - 1, 8'hC3, g);
        chk("late_ack_data", rq_rddata, 8'hC3);
        rq_req = '1;
        tick();
        rq_req = '0;
        chk("glitch_rq_ack", rq_ack, 0);
        tick();
        chk("glitch_ulla_req", ulla_req, 0);
        chk("glitch_busy", busy, 0);

        set_req(2, 1'b0, OTG_CTRL, 8'h3C);
        tick();
        tick();
        chk("pre_rst_ulla_req", ulla_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rq_req = '0;
        chk("mid_rst_ulla_req", ulla_req, 0);
        chk("mid_rst_addr", ulla_addr, 0);
        chk("mid_rst_wrdata", ulla_wrdata, 0);
        chk("mid_rst_rddata", rq_rddata, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_ack", rq_ack, 0);
            tick();
        end
        mptr = 0;
        mrd = '0;
        set_req(0, 1'b0, FUNC_CTRL, 8'h01);
        set_req(1, 1'b0, FUNC_CTRL, 8'h02);
        set_req(2, 1'b0, FUNC_CTRL, 8'h03);
        access(3, 8'h00, g);
        chk("post_rst_first_grant", g, 0);
        rq_req[g] = 1'b0;
        after_comp(g);

        for (int n = 0; n < 40; n++) begin
            if (rq_req == '0) set_req($urandom_range(0, N - 1), 1'($urandom), 8'($urandom), 8'($urandom));
            access($urandom_range(0, T + 3), 8'($urandom), g);
            for (int i = 0; i < N; i++) begin
                if (i == g) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
                    else rq_req[i] = 1'b0;
                end else if (!rq_req[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
                end
            end
            after_comp(g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sc_scbc_ula.md
Name: sc_scbc_ula

Overview:
ULPI low-level access arbiter. It shares the single ULPI register-access channel into the ULPI interface controller among NREQ requesters:
- the port controller's CPU-driven register path
- the port-status poller
- the PHY init sequencer

Arbitration is round-robin. Each access is serialised end-to-end, guarded by a timeout, and returns read data and an error flag to the granted requester. Sits in the ULPICLK domain between the requesters and the ULLA_* / URC_DATA ports of the interface controller.

Parameters:
NREQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, ULPICLK cycles to wait for ULLA_ACK before aborting (>=2)

Ports:
ULPICLK  in  1  ULPI 60 MHz clock
ULPIRST  in  1  synchronous active-high reset
RQ_REQ  in  NREQ  per-requester access request, level
RQ_WR0RD1  in  NREQ  per-requester direction: 0 = write, 1 = read
RQ_ADDR  in  NREQ*8  per-requester ULPI register address; requester i uses bits [8i+7:8i]
RQ_WRDATA  in  NREQ*8  per-requester write data, same packing as RQ_ADDR
RQ_ACK  out  NREQ  one-cycle completion pulse to the granted requester
RQ_ERR  out  1  valid with RQ_ACK; 1 = timed out
RQ_RDDATA  out  8  read data, valid with RQ_ACK, held until next completion
ULLA_REQ  out  1  access request to the interface controller, level
ULLA_ACK  in  1  one-cycle completion from the interface controller
ULLA_WR0RD1  out  1  registered direction of the granted access
ULLA_ADDR  out  8  registered address of the granted access
ULLA_WRDATA  out  8  registered write data of the granted access
URC_DATA  in  8  read data from the interface controller, valid in the ULLA_ACK cycle
BUSY  out  1  high in ISSUE and COMP
GRANT_ID  out  $clog2(NREQ)  index of the current/last grant

Behaviour:
- Reset (sync, ULPIRST=1 at an edge) takes effect on that edge:
  - state=IDLE, pointer=0
  - ULLA_REQ=0, ULLA_WR0RD1=0, ULLA_ADDR=0, ULLA_WRDATA=0
  - RQ_ACK=0, RQ_ERR=0, RQ_RDDATA=0, BUSY=0, GRANT_ID=0
  - timeout counter=0
- Reset mid-access aborts silently: no RQ_ACK is pulsed.
- FSM states: IDLE, ISSUE, COMP.
- IDLE:
  - If any RQ_REQ bit is set, select the first set bit at or after the pointer, scanning upward with wrap-around mod NREQ.
  - On the next edge: latch that requester's WR0RD1/ADDR/WRDATA into the ULLA_* outputs, set GRANT_ID, ULLA_REQ=1, clear the counter, go to ISSUE.
  - Latency: RQ_REQ sampled high at edge k gives ULLA_REQ high after edge k.
- ISSUE:
  - ULLA_REQ and the ULLA_* fields are held stable; the counter increments each cycle.
  - ULLA_ACK=1: capture URC_DATA into RQ_RDDATA (reads only; writes leave it unchanged), RQ_ERR=0, ULLA_REQ=0, go to COMP.
  - Counter reaches TIMEOUT_CYCLES-1 without ULLA_ACK: ULLA_REQ=0, RQ_ERR=1, RQ_RDDATA unchanged, go to COMP.
  - ULLA_ACK and the timeout in the same cycle: the ACK wins (RQ_ERR=0, data captured).
- COMP:
  - RQ_ACK[GRANT_ID]=1 for exactly one cycle.
  - pointer = (GRANT_ID+1) mod NREQ.
  - Go to IDLE. RQ_REQ is not sampled in COMP.
- Requester rules:
  - Hold RQ_REQ and its fields stable from assertion until RQ_ACK.
  - Deassert RQ_REQ on the edge that samples RQ_ACK, unless another access is wanted; keeping it asserted requests a new access.
- Protocol errors:
  - RQ_REQ dropped before RQ_ACK is illegal; the access still completes and RQ_ACK is still pulsed.
  - ULLA_ACK received outside ISSUE is ignored.
- Throughput: one access per (ack latency + 2) cycles. Fairness: every requester is granted within NREQ accesses.
- GRANT_ID holds its last value in IDLE.

Decomposition:
- Shared package sc_scbc_pkg holds:
  - the ula_state_t enum (IDLE/ISSUE/COMP)
  - ULPI register address constants (VENDOR_ID_LO=8'h00, FUNC_CTRL=8'h04, OTG_CTRL=8'h0A, DEBUG=8'h15, SCRATCH=8'h16)
- Sub-module sc_scbc_rrpick is the combinational round-robin picker:
  - inputs: request vector, pointer
  - outputs: grant valid, grant index
- The picker is reused by the future transaction scheduler.

Test Plan:
- Single write, NREQ=3: RQ_REQ[1]=1, ADDR=8'h16, WRDATA=8'hA5, WR0RD1=0.
  - Required: ULLA_REQ rises 1 cycle later with ADDR 16/DATA A5.
  - Required: with ULLA_ACK 5 cycles after ULLA_REQ rises, RQ_ACK[1] pulses the cycle after ULLA_ACK, RQ_ERR=0, GRANT_ID=1.
- Read: RQ_REQ[0] read of 8'h00, URC_DATA=8'h24 with ULLA_ACK.
  - Required: RQ_RDDATA=8'h24 with RQ_ACK[0] and held after.
  - Required: a following write leaves RQ_RDDATA at 8'h24.
- Contention: all three RQ_REQ held high, pointer=0, each ULLA_ACK returned 2 cycles after ULLA_REQ rises.
  - Required grant order: 0,1,2,0,1,2.
  - Required: no RQ_REQ sampled in COMP; ULLA_REQ gap between accesses is exactly 2 cycles.
- Timeout, TIMEOUT_CYCLES=16: ULLA_ACK is never driven.
  - Required: ULLA_REQ is high for exactly 16 cycles, then RQ_ACK pulses with RQ_ERR=1 and RQ_RDDATA unchanged.
  - Variant: ULLA_ACK in the 16th cycle gives RQ_ERR=0.
- Reset mid-access: ULPIRST=1 for 1 cycle while in ISSUE.
  - Required: ULLA_REQ=0 and all outputs at reset values after that edge, no RQ_ACK, next grant starts from requester 0.
- Stray ULLA_ACK in IDLE: no state change and no RQ_ACK pulse.
